// File: rtl/lcd_cmd_sequencer_if.sv
// Command handshake between the script sequencer and the LCD image controller.
interface lcd_cmd_sequencer_if;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       done;

   // Sequencer side
   modport master (
      output cmd,
      output cmd_valid,
      input  busy,
      input  done
   );

   // Controller side
   modport slave (
      input  cmd,
      input  cmd_valid,
      output busy,
      output done
   );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Walks a 4-bit command script held in a synchronous ROM and issues each command to the LCD
// controller over the cmd/cmd_valid/busy handshake. Opcode 0 is the write command and ends
// the script once the controller reports done. Status is sticky until the next start.
module lcd_cmd_sequencer #(
   parameter int unsigned CMD_AW       = 6,
   parameter int unsigned DONE_TIMEOUT = 1023,
   parameter logic [3:0]  NOP_CODE     = 4'hF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                CMD_ROM_rd,
   output logic [CMD_AW-1:0]   CMD_ROM_A,
   input  logic [3:0]          CMD_ROM_Q,
   lcd_cmd_sequencer_if.master ctl,
   output logic                seq_done,
   output logic                seq_err,
   output logic [CMD_AW:0]     issued_cnt
);

   localparam int unsigned TW = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StLatch,
      StReady,
      StIssue,
      StHold,
      StAdvance,
      StWaitDone,
      StFinish
   } state_e;

   state_e        state;
   logic [3:0]    cmd_reg;
   logic [TW-1:0] to_cnt;

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         cmd_reg       <= NOP_CODE;
         to_cnt        <= '0;
         CMD_ROM_rd    <= 1'b0;
         CMD_ROM_A     <= '0;
         ctl.cmd       <= NOP_CODE;
         ctl.cmd_valid <= 1'b0;
         seq_done      <= 1'b0;
         seq_err       <= 1'b0;
         issued_cnt    <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  seq_done   <= 1'b0;
                  seq_err    <= 1'b0;
                  issued_cnt <= '0;
                  CMD_ROM_A  <= '0;
                  CMD_ROM_rd <= 1'b1;
                  state      <= StFetch;
               end
            end
            StFetch: begin
               // ROM read strobe is high for exactly this cycle; data arrives in LATCH
               CMD_ROM_rd <= 1'b0;
               state      <= StLatch;
            end
            StLatch: begin
               cmd_reg <= CMD_ROM_Q;
               if (CMD_ROM_Q[3:2] == 2'b11) begin
                  // Opcodes 12..15 are illegal: flag and skip without issuing
                  seq_err <= 1'b1;
                  state   <= StAdvance;
               end else begin
                  state <= StReady;
               end
            end
            StReady: begin
               if (!ctl.busy) begin
                  ctl.cmd       <= cmd_reg;
                  ctl.cmd_valid <= 1'b1;
                  if (issued_cnt != '1) begin
                     issued_cnt <= issued_cnt + (CMD_AW + 1)'(1);
                  end
                  state <= StIssue;
               end
            end
            StIssue: begin
               ctl.cmd_valid <= 1'b0;
               to_cnt        <= '0;
               if (cmd_reg == 4'h0) begin
                  // Write command: cmd level stays 0 for the whole write-out
                  state <= StWaitDone;
               end else begin
                  ctl.cmd <= NOP_CODE;
                  state   <= StHold;
               end
            end
            StHold: begin
               // Dead cycle so busy is re-sampled no earlier than one cycle after the strobe
               state <= StAdvance;
            end
            StAdvance: begin
               if (CMD_ROM_A == '1) begin
                  // Ran off the end of the ROM without a write command
                  seq_err <= 1'b1;
                  state   <= StFinish;
               end else begin
                  CMD_ROM_A  <= CMD_ROM_A + CMD_AW'(1);
                  CMD_ROM_rd <= 1'b1;
                  state      <= StFetch;
               end
            end
            StWaitDone: begin
               if (ctl.done) begin
                  ctl.cmd <= NOP_CODE;
                  state   <= StFinish;
               end else if (to_cnt == TO_LAST) begin
                  seq_err <= 1'b1;
                  ctl.cmd <= NOP_CODE;
                  state   <= StFinish;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            StFinish: begin
               seq_done <= 1'b1;
               state    <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
